bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter IN_W, default 14: binary input width; legal range 14..16.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; forces reset state immediately while low.
REQ-004 start  input  1  request a conversion of bin_in; sampled on rising clk edge.
REQ-005 bin_in  input  IN_W  unsigned binary value to convert.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  single-cycle pulse marking new valid digits.
REQ-008 ovf  output  1  registered flag: last captured bin_in exceeded 9999.
REQ-009 bcd_thousands  output  4  thousands digit, 0..9.
REQ-010 bcd_hundreds  output  4  hundreds digit, 0..9.
REQ-011 bcd_tens  output  4  tens digit, 0..9.
REQ-012 bcd_ones  output  4  ones digit, 0..9.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 In IDLE with start=1 at edge N, the block SHALL capture the operand, clear the BCD scratch register, load a 4-bit iteration counter with 14, and enter SHIFT.
REQ-015 In IDLE with start=0, the FSM SHALL remain in IDLE.
REQ-016 Operand capture SHALL saturate: bin_in>9999 loads 9999 (14 bits) and sets ovf=1; otherwise it loads bin_in[13:0] and sets ovf=0.
REQ-017 ovf SHALL update only at operand capture.
REQ-018 Each SHIFT cycle SHALL run one double-dabble step: add 3 to every BCD nibble >=5, then shift {bcd,operand} left one bit, then decrement the counter.
REQ-019 After the 14th shift (edge N+14), the FSM SHALL enter DONE.
REQ-020 In DONE (edge N+15), the four output digits SHALL load from the scratch register, done SHALL rise for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-021 Latency from the start-sampling edge to done high SHALL be exactly 15 clock cycles.
REQ-022 The next start SHALL be accepted no earlier than the cycle in which done is high.
REQ-023 busy SHALL be high from edge N through edge N+14, and low whenever done is high or the FSM is in IDLE.
REQ-024 start asserted while busy=1 SHALL be ignored; it is not queued, and the in-flight operand is unaffected.
REQ-025 Output digits SHALL hold their last converted value between done pulses, so the downstream multiplexed display never sees partial results.
REQ-026 Every output digit SHALL be in the range 0..9 at all times.
REQ-027 bin_in changes after capture SHALL NOT affect the conversion in progress.
REQ-028 The counter SHALL never wrap; a zero count in SHIFT SHALL force a transition to DONE.

Reset
REQ-029 While rst=0, the block SHALL force: state=IDLE, busy=0, done=0, ovf=0, all four digits=0, scratch and counter cleared.
REQ-030 Reset asserted mid-conversion SHALL abort the conversion with no done pulse.
REQ-031 After reset deasserts, the first start SHALL behave per REQ-014.
REQ-032 Reset SHALL be applied asynchronously; release SHALL be synchronous to clk.

Verification
REQ-033 Reset, then start with bin_in=1234 -> done exactly 15 cycles later; digits 1,2,3,4; ovf=0.
REQ-034 bin_in=0, then bin_in=9999 -> digits 0,0,0,0, then 9,9,9,9; ovf=0 in both cases.
REQ-035 bin_in=12000 (IN_W=14) -> digits 9,9,9,9; ovf=1; next conversion of 5 -> 0,0,0,5 with ovf=0.
REQ-036 Start 4321, re-pulse start with 1111 at cycle 5, and change bin_in mid-conversion -> a single done; digits 4,3,2,1.
REQ-037 Start 8765, assert rst at cycle 7 -> outputs 0 immediately; no done; a subsequent conversion of 42 -> 0,0,4,2.
REQ-038 Back-to-back: start held high continuously -> done every 16 cycles; digits stable between pulses; each digit <=9 (assertion checks throughout).

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential binary-to-BCD converter (double dabble, 4 digits)
// Inputs above 9999 saturate to 9999 and raise ovf; digits update only on done.
module bin_to_bcd_seq #(
  parameter int IN_W = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] bin_in,
  output logic            busy,
  output logic            done,
  output logic            ovf,
  output logic [3:0]      bcd_thousands,
  output logic [3:0]      bcd_hundreds,
  output logic [3:0]      bcd_tens,
  output logic [3:0]      bcd_ones
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_bcd;
  logic [13:0] r_op;
  logic [3:0]  r_cnt;

  logic        w_sat;
  logic [13:0] w_cap;
  logic [15:0] w_next_bcd;

  // Adjust then shift; the thousands nibble only keeps its low three bits because
  // its top bit is shifted out anyway (and is never set for values up to 9999).
  function automatic logic [15:0] dabble_shift(input logic [15:0] b, input logic in_bit);
    logic [14:0] a;
    a[3:0]   = (b[3:0]   >= 4'd5) ? b[3:0]   + 4'd3 : b[3:0];
    a[7:4]   = (b[7:4]   >= 4'd5) ? b[7:4]   + 4'd3 : b[7:4];
    a[11:8]  = (b[11:8]  >= 4'd5) ? b[11:8]  + 4'd3 : b[11:8];
    a[14:12] = (b[15:12] >= 4'd5) ? b[14:12] + 3'd3 : b[14:12];
    return {a, in_bit};
  endfunction

  assign w_sat      = (bin_in > IN_W'(9999));
  assign w_cap      = w_sat ? 14'd9999 : bin_in[13:0];
  assign w_next_bcd = dabble_shift(r_bcd, r_op[13]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_bcd         <= '0;
      r_op          <= '0;
      r_cnt         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ovf           <= 1'b0;
      bcd_thousands <= '0;
      bcd_hundreds  <= '0;
      bcd_tens      <= '0;
      bcd_ones      <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= w_cap;
            ovf     <= w_sat;
            r_bcd   <= '0;
            r_cnt   <= 4'd14;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
          end else begin
            r_bcd <= w_next_bcd;
            r_op  <= {r_op[12:0], 1'b0};
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          bcd_thousands <= r_bcd[15:12];
          bcd_hundreds  <= r_bcd[11:8];
          bcd_tens      <= r_bcd[7:4];
          bcd_ones      <= r_bcd[3:0];
          done          <= 1'b1;
          busy          <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - scoreboard testbench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

  localparam int IN_W = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [IN_W-1:0] bin_in;
  logic            busy;
  logic            done;
  logic            ovf;
  logic [3:0]      d3, d2, d1, d0;

  typedef struct packed {
    logic [15:0] digits;
    logic        ovf;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_digits;

  bin_to_bcd_seq #(.IN_W(IN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .bin_in        (bin_in),
    .busy          (busy),
    .done          (done),
    .ovf           (ovf),
    .bcd_thousands (d3),
    .bcd_hundreds  (d2),
    .bcd_tens      (d1),
    .bcd_ones      (d0)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int v);
    exp_t e;
    int   s;
    s = (v > 9999) ? 9999 : v;
    e.digits = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    e.ovf    = (v > 9999);
    return e;
  endfunction

  // Scoreboard monitor: pops on done, checks hold, range and busy/done exclusivity
  initial begin
    exp_t e;
    last_digits = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_digits = '0;
      end else if (done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got digits=%h, required no done", {d3, d2, d1, d0});
        end else begin
          e = q.pop_front();
          checks++;
          if ({d3, d2, d1, d0} !== e.digits) begin
            errors++;
            $display("FAIL digits: got %h, required %h", {d3, d2, d1, d0}, e.digits);
          end
          checks++;
          if (ovf !== e.ovf) begin
            errors++;
            $display("FAIL ovf: got %b, required %b", ovf, e.ovf);
          end
          last_digits = e.digits;
        end
      end
      checks++;
      if ({d3, d2, d1, d0} !== last_digits) begin
        errors++;
        $display("FAIL digit_hold: got %h, required %h", {d3, d2, d1, d0}, last_digits);
      end
      checks++;
      if (!(d3 <= 4'd9 && d2 <= 4'd9 && d1 <= 4'd9 && d0 <= 4'd9)) begin
        errors++;
        $display("FAIL digit_range: got %h, required every digit <= 9", {d3, d2, d1, d0});
      end
      checks++;
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done: got busy=1 done=1, required busy=0 while done");
      end
    end
  end

  task automatic run_conv(input int v, output int lat, output logic busy_first,
                          output logic busy_at_done);
    @(negedge clk);
    start  = 1'b1;
    bin_in = IN_W'(v);
    q.push_back(model(v));
    @(negedge clk);
    start        = 1'b0;
    busy_first   = busy;
    lat          = -1;
    busy_at_done = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat          = i;
        busy_at_done = busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    #1 rst = 1'b0;
    #11;
    checks++;
    if ({busy, done, ovf} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/ovf=%b, required 000", {busy, done, ovf});
    end
    checks++;
    if ({d3, d2, d1, d0} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_digits: got %h, required 0000", {d3, d2, d1, d0});
    end
    @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic test_basic();
    int   lat;
    logic bf, bd;
    run_conv(1234, lat, bf, bd);
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL basic_latency: got %0d, required 15", lat);
    end
    checks++;
    if (bf !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_start: got %b, required 1", bf);
    end
    checks++;
    if (bd !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_done: got %b, required 0", bd);
    end
  endtask

  task automatic test_zero_max();
    int   lat;
    logic bf, bd;
    run_conv(0, lat, bf, bd);
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL zero_latency: got %0d, required 15", lat);
    end
    run_conv(9999, lat, bf, bd);
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL max_latency: got %0d, required 15", lat);
    end
  endtask

  task automatic test_ovf();
    int   lat;
    logic bf, bd;
    run_conv(12000, lat, bf, bd);
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL ovf_latency: got %0d, required 15", lat);
    end
    run_conv(5, lat, bf, bd);
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL post_ovf_latency: got %0d, required 15", lat);
    end
  endtask

  task automatic test_restart_ignored();
    int n_done;
    int lat;
    @(negedge clk);
    start  = 1'b1;
    bin_in = IN_W'(4321);
    q.push_back(model(4321));
    @(negedge clk);
    start  = 1'b0;
    n_done = 0;
    lat    = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (lat < 0) lat = i;
      end
      if (i == 5) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL restart_busy: got %b, required 1", busy);
        end
        start  = 1'b1;
        bin_in = IN_W'(1111);
      end
      if (i == 6) start = 1'b0;
      if (i == 8) bin_in = IN_W'(7777);
    end
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL restart_done_count: got %0d, required 1", n_done);
    end
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL restart_latency: got %0d, required 15", lat);
    end
  endtask

  task automatic test_reset_abort();
    int   n_done;
    int   lat;
    logic bf, bd;
    @(negedge clk);
    start  = 1'b1;
    bin_in = IN_W'(8765);
    q.push_back(model(8765));
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    q.delete();
    checks++;
    if ({busy, done, ovf} !== 3'b000) begin
      errors++;
      $display("FAIL abort_flags: got busy/done/ovf=%b, required 000", {busy, done, ovf});
    end
    checks++;
    if ({d3, d2, d1, d0} !== 16'h0000) begin
      errors++;
      $display("FAIL abort_digits: got %h, required 0000", {d3, d2, d1, d0});
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses, required 0", n_done);
    end
    run_conv(42, lat, bf, bd);
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL post_abort_latency: got %0d, required 15", lat);
    end
  endtask

  task automatic test_back_to_back();
    int vals[4] = '{9876, 12345, 1, 5050};
    int cnt;
    @(negedge clk);
    start  = 1'b1;
    bin_in = IN_W'(vals[0]);
    q.push_back(model(vals[0]));
    for (int n = 0; n < 4; n++) begin
      cnt = -1;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (done) begin
          cnt = i;
          break;
        end
      end
      checks++;
      if (cnt !== 16) begin
        errors++;
        $display("FAIL b2b_interval[%0d]: got %0d, required 16", n, cnt);
      end
      if (n < 3) begin
        bin_in = IN_W'(vals[n+1]);
        q.push_back(model(vals[n+1]));
      end else begin
        start = 1'b0;
      end
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_max();
    test_ovf();
    test_restart_ignored();
    test_reset_abort();
    test_back_to_back();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
